// File: rtl/booth_seq_multiplier_if.sv
// Start/busy/done handshake and operand/result bus for the sequential Booth multiplier.
// Handshake: the requester raises start with a/b valid; the multiplier accepts it
// on a rising edge while it is not busy (IDLE or DONE). busy is high for every
// CALC cycle, done pulses for exactly one cycle when product is valid, and product
// then holds until the edge that completes the next accepted operation.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: retires one Booth digit per clock into a
// 2*WIDTH accumulator. The multiplicand register is shifted left by two each
// cycle so the selected partial product is already aligned to digit cnt, and the
// multiplier register is shifted right by two so its low three bits are always
// the current Booth triplet.
module booth_seq_multiplier #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    booth_seq_multiplier_if.slave bus,
    output logic [1:0]          o_state
);
    // Unsigned operands need one extra digit to cover the zero-extended top bits.
    localparam int N  = SIGNED ? (WIDTH / 2) : (WIDTH / 2 + 1);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_last;

    logic [PW-1:0]      r_a;
    logic [WIDTH+2:0]   r_b;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_product;

    logic [PW-1:0]      w_a_ext;
    logic [1:0]         w_b_ext;
    logic [PW-1:0]      w_pp;
    logic [PW-1:0]      w_sum;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_sum    = r_acc + w_pp;

    // Operand extension applied at capture time.
    always_comb begin
        w_a_ext = {{WIDTH{1'b0}}, bus.a};
        w_b_ext = 2'b00;
        if (SIGNED) begin
            w_a_ext = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
            w_b_ext = {2{bus.b[WIDTH-1]}};
        end
    end

    // Booth digit decode of the current triplet into an aligned partial product.
    always_comb begin
        w_pp = '0;
        case (r_b[2:0])
            3'b001, 3'b010: w_pp = r_a;
            3'b011:         w_pp = r_a << 1;
            3'b100:         w_pp = PW'(0) - (r_a << 1);
            3'b101, 3'b110: w_pp = PW'(0) - r_a;
            default:        w_pp = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; DONE re-accepts start for back-to-back use.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_CALC;
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = w_accept ? S_CALC : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: capture operands, accumulate one digit per cycle, publish on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= w_a_ext;
            r_b   <= {w_b_ext, bus.b, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_sum;
            r_a   <= r_a << 2;
            r_b   <= r_b >> 2;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_product <= w_sum;
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;
    assign o_state     = r_state;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: six instances cover WIDTH {4,8,16} x SIGNED {0,1}.
// Index k: WIDTH = 4 (k=0,1), 8 (k=2,3), 16 (k=4,5); SIGNED = k odd.
module tb_booth_seq_multiplier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]  st;
  logic [15:0] ta [6];
  logic [15:0] tbv [6];
  logic [31:0] pr [6];
  logic [5:0]  dn;
  logic [5:0]  bz;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int W = (g < 2) ? 4 : ((g < 4) ? 8 : 16);
    localparam bit S = (g % 2) == 1;
    logic [1:0] dbg_state;
    booth_seq_multiplier_if #(.WIDTH(W)) bus ();
    assign bus.start = st[g];
    assign bus.a     = ta[g][W-1:0];
    assign bus.b     = tbv[g][W-1:0];
    assign pr[g]     = 32'(bus.product);
    assign dn[g]     = bus.done;
    assign bz[g]     = bus.busy;
    booth_seq_multiplier #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .o_state (dbg_state)
    );
  end

  function automatic int wid(int k);
    return (k < 2) ? 4 : ((k < 4) ? 8 : 16);
  endfunction

  function automatic bit sgn(int k);
    return (k % 2) == 1;
  endfunction

  function automatic int nd(int k);
    return sgn(k) ? wid(k) / 2 : wid(k) / 2 + 1;
  endfunction

  // Reference: plain integer multiply of the interpreted operands, truncated to 2*WIDTH.
  function automatic logic [31:0] ref_mul(int k, logic [15:0] a, logic [15:0] b);
    longint m, x, y;
    int w;
    w = wid(k);
    m = longint'(1) << w;
    x = longint'(a) & (m - 1);
    y = longint'(b) & (m - 1);
    if (sgn(k)) begin
      if (x >= m / 2) x = x - m;
      if (y >= m / 2) y = y - m;
    end
    return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an operation in the current cycle and follow it to its done cycle,
  // checking done timing every cycle, busy/hold when detail is set, and the product.
  task automatic op(input int k, input logic [15:0] a, input logic [15:0] b,
                    input logic [31:0] exp, input bit detail);
    int n;
    logic [31:0] held;
    n = nd(k);
    held = pr[k];
    exp_q.push_back(exp);
    st[k] = 1'b1;
    ta[k] = a;
    tbv[k] = b;
    for (int c = 1; c <= n + 1; c++) begin
      tick();
      if (c == 1) begin
        st[k] = 1'b0;
        ta[k] = 16'($urandom);
        tbv[k] = 16'($urandom);
      end
      chk("done_timing", 32'(dn[k]), 32'(c == n + 1));
      if (detail) chk("busy_timing", 32'(bz[k]), 32'(c <= n));
      if (detail && c <= n) chk("product_hold", pr[k], held);
      if (c == n + 1) chk("product", pr[k], exp_q.pop_front());
    end
  endtask

  int lat [6];
  logic [31:0] got [6];
  logic [31:0] expv [6];

  initial begin
    rst = 1'b1;
    st = '0;
    for (int k = 0; k < 6; k++) begin
      ta[k] = '0;
      tbv[k] = '0;
    end
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("reset_product", pr[k], 32'h0);
      chk("reset_done", 32'(dn[k]), 32'h0);
      chk("reset_busy", 32'(bz[k]), 32'h0);
    end

    // Signed 8-bit directed cases.
    op(3, 16'h0007, 16'h00FD, 32'h0000FFEB, 1'b1);
    tick();
    op(3, 16'h0080, 16'h0080, 32'h00004000, 1'b1);
    tick();
    op(3, 16'h0080, 16'h007F, 32'h0000C080, 1'b1);
    tick();
    op(3, 16'h0000, 16'h00FF, 32'h00000000, 1'b1);
    tick();

    // Unsigned 8-bit directed cases.
    op(2, 16'h00FF, 16'h00FF, 32'h0000FE01, 1'b1);
    tick();
    op(2, 16'h00C8, 16'h0003, 32'h00000258, 1'b1);
    tick();

    // Start during CALC is ignored; start in the DONE cycle is accepted.
    st[3] = 1'b1; ta[3] = 16'd5; tbv[3] = 16'd6;
    tick(); st[3] = 1'b0;
    tick(); st[3] = 1'b1; ta[3] = 16'd9; tbv[3] = 16'd9;
    tick(); st[3] = 1'b0;
    chk("ignored_start_busy", 32'(bz[3]), 32'h1);
    tick();
    tick();
    chk("hs_done", 32'(dn[3]), 32'h1);
    chk("hs_product", pr[3], 32'h0000001E);
    op(3, 16'h00FE, 16'h0004, 32'h0000FFF8, 1'b1);
    tick();

    // Reset abort mid-operation.
    st[3] = 1'b1; ta[3] = 16'd3; tbv[3] = 16'd3;
    tick(); st[3] = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk("abort_busy", 32'(bz[3]), 32'h0);
    chk("abort_product", pr[3], 32'h0);
    chk("abort_done", 32'(dn[3]), 32'h0);
    for (int c = 4; c <= 8; c++) begin
      tick();
      chk("abort_no_done", 32'(dn[3]), 32'h0);
    end
    op(3, 16'd3, 16'd3, 32'h00000009, 1'b1);
    tick();

    // Random regression on all six configurations in parallel.
    for (int it = 0; it < 1000; it++) begin
      for (int k = 0; k < 6; k++) begin
        st[k] = 1'b1;
        ta[k] = 16'($urandom_range(0, 65535));
        tbv[k] = 16'($urandom_range(0, 65535));
        expv[k] = ref_mul(k, ta[k], tbv[k]);
        lat[k] = 0;
        got[k] = '0;
      end
      for (int c = 1; c <= 14; c++) begin
        tick();
        if (c == 1) begin
          st = '0;
          for (int k = 0; k < 6; k++) begin
            ta[k] = 16'($urandom);
            tbv[k] = 16'($urandom);
          end
        end
        for (int k = 0; k < 6; k++) begin
          if (dn[k] && lat[k] == 0) begin
            lat[k] = c;
            got[k] = pr[k];
          end
        end
      end
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("rand_latency_k%0d", k), 32'(lat[k]), 32'(nd(k) + 1));
        chk($sformatf("rand_product_k%0d", k), got[k], expv[k]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Parametrised sequential radix-4 Booth multiplier. Retires one Booth digit per clock into a 2*WIDTH accumulator.
- Supports signed (two's complement) and unsigned operands, selected at elaboration time.
- Sits in the datapath wherever area matters more than latency. Uses a start/busy/done handshake and holds its result until the next accepted start.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 4.
- SIGNED, 1, 1 = two's-complement operands; 0 = unsigned operands.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high while in CALC.
- done  output  1  single-cycle pulse when the product is valid.
- product  output  2*WIDTH  result; holds its value until the next accepted start.

Behaviour:
- Digit count: N = WIDTH/2 when SIGNED=1; N = WIDTH/2+1 when SIGNED=0.
  - For unsigned operation, b is zero-extended by 2 bits and a is zero-extended to 2*WIDTH.
  - For signed operation, a is sign-extended to 2*WIDTH.
- Booth digit i is formed from the triplet (b[2i+1], b[2i], b[2i-1]), with b[-1] = 0.
  - 000 and 111 -> 0
  - 001 and 010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101 and 110 -> -A
- The partial product for digit i is shifted left by 2i and added modulo 2^(2*WIDTH).
- States and transitions:
  - IDLE: wait for start. On the edge where start is high, capture a and b, clear the accumulator, set cnt = 0, and go to CALC.
  - CALC: on each edge, add the digit-cnt partial product and increment cnt. On the edge that processes digit N-1, load product with the final sum and go to DONE.
  - DONE: done = 1 for this single cycle, then return to IDLE. A start in this cycle is accepted exactly as in IDLE (back-to-back operation); done still pulses for this cycle.
- Latency: start is high in cycle 0 and accepted at the end of cycle 0.
  - busy is high in cycles 1..N and done is high in cycle N+1.
  - For WIDTH=8: signed gives done in cycle 5; unsigned gives done in cycle 6.
- busy is low in IDLE and DONE. start during CALC is ignored, with no effect on the operation in flight.
- product changes only on the edge that enters DONE. It is not cleared by a new start and stays stable through the next CALC phase.
- a and b may change freely after acceptance; only the captured copies are used.
- Reset, whether in IDLE or mid-operation:
  - state goes to IDLE; busy = 0, done = 0, product = 0.
  - cnt and the accumulator are cleared; no done pulse is produced for the aborted operation.
  - rst has priority over start in the same cycle.
- Overflow cannot occur: the full 2*WIDTH product is always representable.

Test Plan:
- WIDTH=8, SIGNED=1; a=7, b=-3 (8'hFD); start in cycle 0 -> busy high in cycles 1-4, done in cycle 5, product = 16'hFFEB (-21).
- WIDTH=8, SIGNED=1 corners:
  - a=-128, b=-128 -> product 16'h4000.
  - a=-128, b=127 -> product 16'hC080.
  - a=0, b=-1 -> product 16'h0000.
- WIDTH=8, SIGNED=0; a=255, b=255 -> done in cycle 6, product = 16'hFE01. Also a=200, b=3 -> product 16'h0258.
- Handshake: a=5, b=6 accepted; start pulsed with a=9, b=9 in cycle 2 -> ignored, product = 16'h001E. Then start in the DONE cycle with a=-2, b=4 -> accepted, next done 5 cycles later with product 16'hFFF8, and the earlier 16'h001E held until then.
- Reset abort: start a=3, b=3; rst high in cycle 2 -> busy = 0, product = 0 in cycle 3, and no done in cycles 3-8. A new start then completes normally with product 16'h0009.
- Random regression: WIDTH ∈ {4, 8, 16} × SIGNED ∈ {0, 1}, 1000 operand pairs each -> product matches the reference multiply, and done latency is exactly N+1 cycles.
